// File: rtl/ipu_pkg.sv
// Shared constants and elaboration-time helpers for the instruction prefetch unit.
package ipu_pkg;

    localparam int unsigned BITS_PER_BYTE = 8;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) res = i + 1;
        end
        return res;
    endfunction

    function automatic int unsigned pc_inc(input int unsigned data_w);
        return data_w / BITS_PER_BYTE;
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO with wrap-bit pointers, a zero-latency head and a synchronous flush.
module prefetch_fifo
    import ipu_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        wdata_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        rdata_o,
    output logic                    empty_o,
    output logic [clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW = clog2(DEPTH);
    localparam logic [PtrW:0] PtrOne = (PtrW + 1)'(1);

    logic [PtrW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic               full, do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[PtrW-1:0]];

    always_comb begin
        do_push  = push_i && !full && !flush_i;
        do_pop   = pop_i && !empty_o && !flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            // Emptying by catching the read pointer up keeps the write side untouched.
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetcher: credit-limited pipelined fetch, PC-tagged queue, redirect with
// flush and discard of stale in-flight responses.
module instr_prefetch_unit
    import ipu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       MAX_OUT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    imem_req,
    output logic [ADDR_W-1:0]       imem_addr,
    input  logic                    imem_gnt,
    input  logic                    imem_rvalid,
    input  logic [DATA_W-1:0]       imem_rdata,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [DATA_W-1:0]       inst_data,
    output logic [ADDR_W-1:0]       inst_pc,
    input  logic                    redirect_valid,
    input  logic [ADDR_W-1:0]       redirect_pc,
    output logic [clog2(DEPTH):0]   occupancy,
    output logic                    err_spurious
);

    localparam int unsigned       CntW      = clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] PcInc     = ADDR_W'(pc_inc(DATA_W));
    localparam logic [ADDR_W-1:0] AlignMask = ~(PcInc - ADDR_W'(1));
    localparam logic [CntW:0]     DepthW    = (CntW + 1)'(DEPTH);
    localparam logic [CntW-1:0]   MaxOutW   = CntW'(MAX_OUT);
    localparam logic [CntW-1:0]   CntOne    = CntW'(1);

    logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic [CntW-1:0]          outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
    logic                     err_q, err_d, run_q;
    logic                     accept, resp_ok, push, pop, fifo_empty;
    logic [CntW:0]            in_use;
    logic [DATA_W+ADDR_W-1:0] head;

    // Slots already promised: queued words plus in-flight words that will be kept.
    assign in_use     = {1'b0, occupancy} + {1'b0, outstanding_q} - {1'b0, drop_cnt_q};
    assign imem_req   = run_q && !redirect_valid && (outstanding_q < MaxOutW) && (in_use < DepthW);
    assign imem_addr  = fetch_pc_q;
    assign accept     = imem_req && imem_gnt;
    assign resp_ok    = imem_rvalid && (outstanding_q != '0);
    assign push       = resp_ok && !redirect_valid && (drop_cnt_q == '0);
    assign pop        = inst_valid && inst_ready;
    assign inst_valid = !fifo_empty;
    assign inst_data  = head[DATA_W+ADDR_W-1:ADDR_W];
    assign inst_pc    = head[ADDR_W-1:0];
    assign err_spurious = err_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        err_d         = err_q || (imem_rvalid && (outstanding_q == '0));
        if (accept)  outstanding_d = outstanding_d + CntOne;
        if (resp_ok) outstanding_d = outstanding_d - CntOne;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & AlignMask;
            resp_pc_d  = redirect_pc & AlignMask;
            drop_cnt_d = resp_ok ? (outstanding_q - CntOne) : outstanding_q;
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + PcInc;
            if (resp_ok && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CntOne;
            if (push) resp_pc_d = resp_pc_q + PcInc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            err_q         <= 1'b0;
            run_q         <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            err_q         <= err_d;
            run_q         <= 1'b1;
        end
    end

    prefetch_fifo #(
        .WIDTH (DATA_W + ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_valid),
        .push_i  (push),
        .wdata_i ({imem_rdata, resp_pc_q}),
        .pop_i   (pop),
        .rdata_o (head),
        .empty_o (fifo_empty),
        .count_o (occupancy)
    );

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Self-checking bench for instr_prefetch_unit: in-order memory model with scoreboard.
module tb_instr_prefetch_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        imem_req, imem_gnt, imem_rvalid, inst_valid, inst_ready;
    logic        redirect_valid, err_spurious;
    logic [31:0] imem_addr, imem_rdata, inst_data, inst_pc, redirect_pc;
    logic [2:0]  occupancy;

    logic        w_req, w_rvalid, w_valid, w_err;
    logic [31:0] w_addr, w_rdata, w_data, w_pc;
    logic [2:0]  w_occ;

    instr_prefetch_unit #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(4), .MAX_OUT(2), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
        .inst_pc(inst_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .occupancy(occupancy), .err_spurious(err_spurious)
    );

    instr_prefetch_unit #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(4), .MAX_OUT(2), .RESET_PC(32'hFFFF_FFF8)
    ) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(1'b1),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .inst_valid(w_valid), .inst_ready(1'b1), .inst_data(w_data),
        .inst_pc(w_pc), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .occupancy(w_occ), .err_spurious(w_err)
    );

    typedef struct { logic [31:0] addr; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    typedef struct { logic [31:0] target; logic [31:0] exp_pc; logic [31:0] exp_next; } vec_t;

    req_t        pend[$];
    exp_t        sb[$];
    logic [31:0] popped[$];
    logic [31:0] wlog[$];
    logic [31:0] wdlog[$];
    vec_t        vecs[4];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lat = 1;
    bit          force_spur = 0;
    bit          found;
    logic [31:0] exp_fetch = 32'h0;
    logic        w_acc_prev = 1'b0;
    logic [31:0] w_addr_prev = 32'h0;
    int          n0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] popped_at(input int i);
        if (i < popped.size()) return popped[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mem_drive();
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rvalid = force_spur;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        w_rvalid = w_acc_prev;
        w_rdata  = mem_word(w_addr_prev);
    endtask

    task automatic finish_cycle();
        exp_t e;
        #4;
        if (redirect_valid) check("req_in_redirect", imem_req, 32'h0);
        if (imem_req && imem_gnt) begin
            check("fetch_addr", imem_addr, exp_fetch);
            pend.push_back('{addr: imem_addr, due: cyc + lat});
            sb.push_back('{pc: exp_fetch, data: mem_word(exp_fetch)});
            exp_fetch = exp_fetch + 32'd4;
        end
        if (inst_valid && inst_ready && !redirect_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got pc %h with nothing expected", inst_pc);
            end else begin
                e = sb.pop_front();
                check("inst_pc", inst_pc, e.pc);
                check("inst_data", inst_data, e.data);
            end
            popped.push_back(inst_pc);
        end
        if (redirect_valid) begin
            sb.delete();
            exp_fetch = redirect_pc & 32'hFFFF_FFFC;
        end
        w_acc_prev  = w_req;
        w_addr_prev = w_addr;
        if (w_valid && wlog.size() < 3) begin
            wlog.push_back(w_pc);
            wdlog.push_back(w_data);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic step();
        mem_drive();
        finish_cycle();
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic run_until(input int n, input int budget);
        int k;
        k = 0;
        while (popped.size() < n && k < budget) begin
            step();
            k++;
        end
        if (popped.size() < n) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d pops required %0d", popped.size(), n);
        end
    endtask

    initial begin
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; inst_ready = 0;
        redirect_valid = 0; redirect_pc = 0; w_rvalid = 0; w_rdata = 0;
        vecs[0] = '{target: 32'h0000_0103, exp_pc: 32'h0000_0100, exp_next: 32'h0000_0104};
        vecs[1] = '{target: 32'hFFFF_FFF8, exp_pc: 32'hFFFF_FFF8, exp_next: 32'hFFFF_FFFC};
        vecs[2] = '{target: 32'h0000_2002, exp_pc: 32'h0000_2000, exp_next: 32'h0000_2004};
        vecs[3] = '{target: 32'hFFFF_FFFF, exp_pc: 32'hFFFF_FFFC, exp_next: 32'h0000_0000};

        // Reset values
        #1;
        check("rst_req", imem_req, 0);
        check("rst_valid", inst_valid, 0);
        check("rst_occ", occupancy, 0);
        check("rst_err", err_spurious, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Spurious response with nothing outstanding
        imem_gnt = 0;
        force_spur = 1;
        step();
        force_spur = 0;
        step();
        step();
        check("spur_err", err_spurious, 1);
        check("spur_occ", occupancy, 0);
        check("spur_valid", inst_valid, 0);

        // Streaming from RESET_PC, 1-cycle latency
        imem_gnt = 1; inst_ready = 1; lat = 1;
        popped.delete();
        repeat (10) step();
        check("stream_pc0", popped_at(0), 32'h0);
        check("stream_pc1", popped_at(1), 32'h4);
        check("stream_pc2", popped_at(2), 32'h8);
        n0 = popped.size();
        repeat (10) step();
        check("stream_rate", popped.size() - n0, 10);

        // Back-pressure fill
        inst_ready = 0;
        do_redirect(32'h400);
        repeat (12) step();
        check("fill_occ", occupancy, 4);
        check("fill_req", imem_req, 0);
        check("fill_valid", inst_valid, 1);
        check("fill_head", inst_pc, 32'h400);
        popped.delete();
        inst_ready = 1;
        run_until(8, 40);
        check("fill_pc0", popped_at(0), 32'h400);
        check("fill_pc4", popped_at(4), 32'h410);
        check("fill_pc7", popped_at(7), 32'h41C);

        // Redirect with two requests outstanding, latency 3
        lat = 3;
        repeat (6) step();
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            mem_drive();
            if (pend.size() == 2 && !imem_rvalid) begin
                found = 1;
                redirect_valid = 1;
                redirect_pc = 32'h100;
            end
            finish_cycle();
            redirect_valid = 0;
        end
        if (!found) begin
            total++; bad++;
            $display("FAIL redir_setup: got no cycle with 2 outstanding");
        end
        check("l3_flush_occ", occupancy, 0);
        popped.delete();
        run_until(2, 40);
        check("l3_pc0", popped_at(0), 32'h100);
        check("l3_pc1", popped_at(1), 32'h104);

        // Redirect coinciding with a response and a pop, latency 2
        lat = 2;
        inst_ready = 0;
        do_redirect(32'h300);
        repeat (14) step();
        inst_ready = 1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            mem_drive();
            if (imem_rvalid && pend.size() == 1 && inst_valid) begin
                found = 1;
                redirect_valid = 1;
                redirect_pc = 32'h200;
            end
            finish_cycle();
            redirect_valid = 0;
        end
        if (!found) begin
            total++; bad++;
            $display("FAIL redir_pop_setup: got no cycle with rvalid and pop");
        end
        check("rp_occ", occupancy, 0);
        check("rp_valid", inst_valid, 0);
        popped.delete();
        run_until(3, 40);
        check("rp_pc0", popped_at(0), 32'h200);
        check("rp_pc2", popped_at(2), 32'h208);

        // Redirect alignment and wrap table
        lat = 1;
        for (int i = 0; i < 4; i++) begin
            do_redirect(vecs[i].target);
            popped.delete();
            run_until(2, 30);
            check("vec_pc0", popped_at(0), vecs[i].exp_pc);
            check("vec_pc1", popped_at(1), vecs[i].exp_next);
        end

        // Random grant/ready/redirect traffic
        lat = 2;
        for (int i = 0; i < 200; i++) begin
            imem_gnt   = ($urandom_range(0, 3) != 0);
            inst_ready = ($urandom_range(0, 1) != 0);
            if ($urandom_range(0, 19) == 0) do_redirect($urandom & 32'h0000_FFFF);
            else step();
        end
        imem_gnt = 1; inst_ready = 1;
        repeat (10) step();
        check("err_sticky", err_spurious, 1);

        // Asynchronous reset mid-stream
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", imem_req, 0);
        check("arst_valid", inst_valid, 0);
        check("arst_occ", occupancy, 0);
        check("arst_err", err_spurious, 0);
        pend.delete(); sb.delete();
        exp_fetch = 32'h0; imem_rvalid = 0; w_acc_prev = 0; w_rvalid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        popped.delete();
        lat = 1;
        run_until(2, 20);
        check("arst_pc0", popped_at(0), 32'h0);
        check("arst_pc1", popped_at(1), 32'h4);

        // Wrap instance: PC sequence across 2^32
        for (int i = 0; i < 3; i++) begin
            logic [31:0] epc;
            epc = 32'hFFFF_FFF8 + 32'(4 * i);
            check("wrap_pc", (i < wlog.size()) ? wlog[i] : 32'hxxxx_xxxx, epc);
            check("wrap_data", (i < wdlog.size()) ? wdlog[i] : 32'hxxxx_xxxx, mem_word(epc));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
